module_bcd_conv_arbiter: RTL and testbench

Sequential, shared binary-to-BCD conversion engine. Two requesters are served by round-robin arbitration. One shift-add-3 (double-dabble) iteration runs per clock, so a conversion takes WIDTH cycles. The block sits between the arithmetic/result logic and the 7-segment display path. It replaces per-source combinational converters, and each channel keeps its own registered BCD result.

---
 rtl/module_bcd_conv_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_module_bcd_conv_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_bcd_conv_arbiter.sv
// ----------------------------------------------------------------------------
// module_bcd_conv_arbiter
// Shared sequential binary-to-BCD converter (double-dabble, one iteration per
// clock) serving two requesters with round-robin arbitration. Each channel
// keeps its own registered BCD result.
//
// Optional feature: define BCD_LEADING_BLANK_EN to add per-channel leading-
// zero blanking masks (o_blank0 / o_blank1).
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_req     per-channel conversion request (level, bit k = channel k)
//   i_bin0/1  channel operands, sampled when the request is accepted
//   o_ack     one-cycle pulse, request accepted
//   o_done    one-cycle pulse, channel result updated
//   o_busy    conversion in flight
//   o_grant   channel owning the engine (valid while o_busy)
//   o_bcd0/1  per-channel BCD results, digit 0 in [3:0]
//   o_blank0/1 (BCD_LEADING_BLANK_EN only) leading-zero blanking masks
// ----------------------------------------------------------------------------
module module_bcd_conv_arbiter #(
   parameter int unsigned WIDTH  = 12,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [1:0]            i_req,
   input  logic [WIDTH-1:0]      i_bin0,
   input  logic [WIDTH-1:0]      i_bin1,
   output logic [1:0]            o_ack,
   output logic [1:0]            o_done,
   output logic                  o_busy,
   output logic                  o_grant,
   output logic [4*DIGITS-1:0]   o_bcd0,
   output logic [4*DIGITS-1:0]   o_bcd1
`ifdef BCD_LEADING_BLANK_EN
   ,
   output logic [DIGITS-1:0]     o_blank0,
   output logic [DIGITS-1:0]     o_blank1
`endif
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   // Elaboration guard: the BCD field must hold the largest operand.
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam longint unsigned DEC_RANGE = pow10(DIGITS);
   localparam longint unsigned BIN_MAX   = (64'd1 << WIDTH) - 64'd1;

   generate
      if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
         $error("module_bcd_conv_arbiter: DIGITS too small for WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic               last_grant;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   shreg;
   logic [BCD_W-1:0]   acc;

   logic [BCD_W-1:0]   acc_adj_c;
   logic [BCD_W-1:0]   acc_next_c;
   logic               sel_c;

   // Add-3 correction on every nibble >= 5, then shift in the operand MSB.
   always_comb begin
      acc_adj_c = acc;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
      acc_next_c = {acc_adj_c[BCD_W-2:0], shreg[WIDTH-1]};
   end

   // Round-robin pick: single request wins outright, a tie goes away from
   // the last served channel.
   always_comb begin
      sel_c = i_req[1];
      if (i_req == 2'b11) begin
         sel_c = ~last_grant;
      end
   end

`ifdef BCD_LEADING_BLANK_EN
   logic [DIGITS-1:0] blank_c;

   // Digit i blanks when it and every higher digit is zero; digit 0 never blanks.
   always_comb begin
      blank_c = '0;
      blank_c[DIGITS-1] = (acc[BCD_W-1 -: 4] == 4'd0);
      for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
         blank_c[i] = blank_c[i+1] && (acc[4*i +: 4] == 4'd0);
      end
      blank_c[0] = 1'b0;
   end
`endif

   // Control FSM, datapath and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         shreg      <= '0;
         acc        <= '0;
         o_ack      <= 2'b00;
         o_done     <= 2'b00;
         o_busy     <= 1'b0;
         o_grant    <= 1'b0;
         o_bcd0     <= '0;
         o_bcd1     <= '0;
`ifdef BCD_LEADING_BLANK_EN
         o_blank0   <= {{(DIGITS-1){1'b1}}, 1'b0};
         o_blank1   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
      end else begin
         o_ack  <= 2'b00;
         o_done <= 2'b00;
         case (state)
            IDLE: begin
               o_busy <= 1'b0;
               if (i_req != 2'b00) begin
                  shreg   <= sel_c ? i_bin1 : i_bin0;
                  acc     <= '0;
                  o_grant <= sel_c;
                  cnt     <= CNT_W'(WIDTH);
                  o_ack   <= sel_c ? 2'b10 : 2'b01;
                  o_busy  <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               acc   <= acc_next_c;
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (o_grant) begin
                  o_bcd1   <= acc;
`ifdef BCD_LEADING_BLANK_EN
                  o_blank1 <= blank_c;
`endif
                  o_done   <= 2'b10;
               end else begin
                  o_bcd0   <= acc;
`ifdef BCD_LEADING_BLANK_EN
                  o_blank0 <= blank_c;
`endif
                  o_done   <= 2'b01;
               end
               last_grant <= o_grant;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_bcd_conv_arbiter.sv
// ----------------------------------------------------------------------------
// tb_module_bcd_conv_arbiter
// Directed bench for module_bcd_conv_arbiter (WIDTH=12, DIGITS=4). Expected
// results are queued when requests are driven and popped when o_done fires.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_module_bcd_conv_arbiter;

   localparam int unsigned WIDTH  = 12;
   localparam int unsigned DIGITS = 4;

   logic        i_clk;
   logic        i_rst_n;
   logic [1:0]  i_req;
   logic [11:0] i_bin0;
   logic [11:0] i_bin1;
   logic [1:0]  o_ack;
   logic [1:0]  o_done;
   logic        o_busy;
   logic        o_grant;
   logic [15:0] o_bcd0;
   logic [15:0] o_bcd1;
`ifdef BCD_LEADING_BLANK_EN
   logic [3:0]  o_blank0;
   logic [3:0]  o_blank1;
`endif

   module_bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (i_req),
      .i_bin0  (i_bin0),
      .i_bin1  (i_bin1),
      .o_ack   (o_ack),
      .o_done  (o_done),
      .o_busy  (o_busy),
      .o_grant (o_grant),
      .o_bcd0  (o_bcd0),
      .o_bcd1  (o_bcd1)
`ifdef BCD_LEADING_BLANK_EN
      ,
      .o_blank0 (o_blank0),
      .o_blank1 (o_blank1)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        ch;
      int          val;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          ack1_cnt = 0;
   logic [1:0]  prev_ack = 2'b00;
   logic [15:0] m_bcd0   = 16'h0;
   logic [15:0] m_bcd1   = 16'h0;

   // Golden decimal conversion by repeated division.
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          t;
      r = '0;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] blank_of(input logic [15:0] b);
      logic [3:0] m;
      m = 4'b0000;
      m[3] = (b[15:12] == 4'd0);
      m[2] = m[3] && (b[11:8] == 4'd0);
      m[1] = m[2] && (b[7:4] == 4'd0);
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge i_clk);
         cyc++;
      end
   end

   // Monitor: ack pulse shape and scoreboard comparison on every o_done.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            prev_ack = 2'b00;
         end else begin
            if (o_ack != 2'b00) begin
               check("ack_one_cycle", 32'(prev_ack), 32'h0);
               if (o_ack[1]) ack1_cnt++;
            end
            prev_ack = o_ack;
            if (o_done != 2'b00) begin
               if (sb_q.size() == 0) begin
                  check("done_unexpected", 32'(o_done), 32'h0);
               end else begin
                  e = sb_q.pop_front();
                  check("done_channel", 32'(o_done), e.ch ? 32'h2 : 32'h1);
                  check("done_busy", 32'(o_busy), 32'h1);
                  if (e.ch) begin
                     check("bcd1_value", 32'(o_bcd1), 32'(to_bcd(e.val)));
                     check("bcd0_untouched", 32'(o_bcd0), 32'(m_bcd0));
                     m_bcd1 = to_bcd(e.val);
`ifdef BCD_LEADING_BLANK_EN
                     check("blank1_value", 32'(o_blank1), 32'(blank_of(m_bcd1)));
`endif
                  end else begin
                     check("bcd0_value", 32'(o_bcd0), 32'(to_bcd(e.val)));
                     check("bcd1_untouched", 32'(o_bcd1), 32'(m_bcd1));
                     m_bcd0 = to_bcd(e.val);
`ifdef BCD_LEADING_BLANK_EN
                     check("blank0_value", 32'(o_blank0), 32'(blank_of(m_bcd0)));
`endif
                  end
               end
            end
         end
      end
   end

   function automatic exp_t mk(input logic ch, input int val);
      exp_t e;
      e.ch  = ch;
      e.val = val;
      return e;
   endfunction

   task automatic wait_ack(input logic ch, output int at_cyc);
      bit seen;
      seen = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge i_clk);
         #1;
         if (o_ack != 2'b00) begin
            seen = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
      check("ack_seen", 32'(seen), 32'h1);
      if (seen) begin
         check("ack_channel", 32'(o_ack), ch ? 32'h2 : 32'h1);
         check("grant_at_ack", 32'(o_grant), 32'(ch));
         check("busy_at_ack", 32'(o_busy), 32'h1);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         #1;
         if (!o_busy && sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_reached", 32'(ok), 32'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},  32'(o_ack),   32'h0);
      check({tag, "_done"}, 32'(o_done),  32'h0);
      check({tag, "_busy"}, 32'(o_busy),  32'h0);
      check({tag, "_grant"},32'(o_grant), 32'h0);
      check({tag, "_bcd0"}, 32'(o_bcd0),  32'h0);
      check({tag, "_bcd1"}, 32'(o_bcd1),  32'h0);
`ifdef BCD_LEADING_BLANK_EN
      check({tag, "_blank0"}, 32'(o_blank0), 32'he);
      check({tag, "_blank1"}, 32'(o_blank1), 32'he);
`endif
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst_n = 1'b0;
      i_req   = 2'b00;
      sb_q.delete();
      m_bcd0 = 16'h0;
      m_bcd1 = 16'h0;
      repeat (2) @(negedge i_clk);
      check_reset_outputs("reset");
      i_rst_n = 1'b1;
   endtask

   initial begin
      int a0;
      int a1;
      int t;
      int busy_low;
      int acks_before;
      int sweep[12];
      bit got_done;

      sweep = '{0, 1, 4, 5, 9, 10, 99, 100, 999, 1000, 4094, 4095};
      i_rst_n = 1'b0;
      i_req   = 2'b00;
      i_bin0  = '0;
      i_bin1  = '0;

      // Reset state.
      do_reset();

      // Single conversion on channel 0, latency and busy coverage.
      i_bin0 = 12'd4095;
      i_req  = 2'b01;
      sb_q.push_back(mk(1'b0, 4095));
      wait_ack(1'b0, a0);
      i_req = 2'b00;
      busy_low = 0;
      got_done = 1'b0;
      t = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge i_clk);
         #1;
         if (o_done != 2'b00) begin
            got_done = 1'b1;
            t = cyc - a0;
            break;
         end
         if (!o_busy) busy_low++;
      end
      check("done_seen", 32'(got_done), 32'h1);
      check("done_latency", 32'(t), 32'(WIDTH + 1));
      check("busy_throughout", 32'(busy_low), 32'h0);
      @(negedge i_clk);
      #1;
      check("busy_after_done", 32'(o_busy), 32'h0);
      check("bcd0_4095", 32'(o_bcd0), 32'h4095);
      check("bcd1_zero", 32'(o_bcd1), 32'h0);

      // Both requests together from reset: channel 0 first, back-to-back spacing.
      do_reset();
      i_bin0 = 12'd255;
      i_bin1 = 12'd1000;
      i_req  = 2'b11;
      sb_q.push_back(mk(1'b0, 255));
      sb_q.push_back(mk(1'b1, 1000));
      wait_ack(1'b0, a0);
      i_req[0] = 1'b0;
      wait_ack(1'b1, a1);
      i_req = 2'b00;
      check("ack_spacing", 32'(a1 - a0), 32'(WIDTH + 2));
      wait_idle();
      check("bcd0_255", 32'(o_bcd0), 32'h0255);
      check("bcd1_1000", 32'(o_bcd1), 32'h1000);

      // Both held for four conversions: last grant was 1, so 0,1,0,1.
      i_bin0 = 12'd11;
      i_bin1 = 12'd22;
      i_req  = 2'b11;
      sb_q.push_back(mk(1'b0, 11));
      sb_q.push_back(mk(1'b1, 22));
      sb_q.push_back(mk(1'b0, 333));
      sb_q.push_back(mk(1'b1, 4000));
      wait_ack(1'b0, a0);
      i_bin0 = 12'd333;
      wait_ack(1'b1, a0);
      i_bin1 = 12'd4000;
      wait_ack(1'b0, a0);
      i_req[0] = 1'b0;
      i_bin0 = 12'd7;
      wait_ack(1'b1, a0);
      i_req = 2'b00;
      wait_idle();

      // Reset in the middle of a conversion discards it.
      i_bin0 = 12'd1234;
      i_req  = 2'b01;
      wait_ack(1'b0, a0);
      i_req = 2'b00;
      repeat (6) @(negedge i_clk);
      #1;
      i_rst_n = 1'b0;
      #1;
      m_bcd0 = 16'h0;
      m_bcd1 = 16'h0;
      check_reset_outputs("midreset");
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (20) @(negedge i_clk);
      i_bin1 = 12'd77;
      i_req  = 2'b10;
      sb_q.push_back(mk(1'b1, 77));
      wait_ack(1'b1, a0);
      i_req = 2'b00;
      wait_idle();
      check("after_reset_bcd1", 32'(o_bcd1), 32'h0077);
      check("after_reset_bcd0", 32'(o_bcd0), 32'h0);

      // Operand sweep on channel 0.
      foreach (sweep[k]) begin
         i_bin0 = 12'(sweep[k]);
         i_req  = 2'b01;
         sb_q.push_back(mk(1'b0, sweep[k]));
         wait_ack(1'b0, a0);
         i_req = 2'b00;
         wait_idle();
`ifdef BCD_LEADING_BLANK_EN
         if (sweep[k] == 0)   check("blank0_of_0",   32'(o_blank0), 32'he);
         if (sweep[k] == 100) check("blank0_of_100", 32'(o_blank0), 32'h8);
`endif
      end

      // Channel 1 request dropped before ack while channel 0 converts.
      acks_before = ack1_cnt;
      i_bin0 = 12'd42;
      i_req  = 2'b01;
      sb_q.push_back(mk(1'b0, 42));
      wait_ack(1'b0, a0);
      i_req  = 2'b10;
      i_bin1 = 12'd999;
      repeat (5) @(negedge i_clk);
      i_req = 2'b00;
      wait_idle();
      check("dropped_no_ack", 32'(ack1_cnt - acks_before), 32'h0);
      check("dropped_bcd1_kept", 32'(o_bcd1), 32'h0077);
      // Last grant is still 0, so a tie now goes to channel 1.
      i_bin0 = 12'd5;
      i_bin1 = 12'd6;
      i_req  = 2'b11;
      sb_q.push_back(mk(1'b1, 6));
      sb_q.push_back(mk(1'b0, 5));
      wait_ack(1'b1, a0);
      i_req[1] = 1'b0;
      wait_ack(1'b0, a0);
      i_req = 2'b00;
      wait_idle();
      check("final_bcd0", 32'(o_bcd0), 32'h0005);
      check("final_bcd1", 32'(o_bcd1), 32'h0006);

      repeat (3) @(negedge i_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
